// File: rtl/seq_mult.sv
`default_nettype none
// ============================================================================
//  Module   : seq_mult
//  Purpose  : Sequential shift-and-add multiplier, W-bit operands, 2W-bit
//             product after exactly W cycles. Per-operation mode selects
//             unsigned or two's-complement signed multiplication.
//  Ports    :
//    clk    in   1    rising-edge clock
//    rst_n  in   1    asynchronous active-low reset
//    start  in   1    operation request, sampled only while busy=0
//    sgn    in   1    1 = signed operands, 0 = unsigned (sampled with start)
//    a      in   W    multiplicand (sampled with start)
//    b      in   W    multiplier (sampled with start)
//    busy   out  1    operation in progress
//    done   out  1    one-cycle pulse when p is updated
//    p      out  2W   product, held until the next completion
//  Revision : 1.0  initial release
// ============================================================================
module seq_mult #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           sgn,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] p
);

  localparam int CW = $clog2(W) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state;
  logic [W-1:0]   mc;
  logic [W-1:0]   mp;
  logic [2*W-1:0] acc;
  logic [CW-1:0]  cnt;
  logic           neg;

  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic [W:0]     sum;
  logic [2*W-1:0] acc_nxt;
  logic [2*W-1:0] prod_nxt;
  logic           last_iter;
  logic           unused_acc_lsb;

  // Two's-complement absolute value. For -2^(W-1) the W-bit result is
  // 2^(W-1), which is exactly right when read as unsigned.
  assign a_mag = (sgn && a[W-1]) ? (~a + {{(W-1){1'b0}}, 1'b1}) : a;
  assign b_mag = (sgn && b[W-1]) ? (~b + {{(W-1){1'b0}}, 1'b1}) : b;

  // Conditional add into the upper half with carry out, then the carry
  // becomes the new MSB as the accumulator shifts right. The old LSB of
  // acc falls off the end.
  assign sum            = {1'b0, acc[2*W-1:W]} + {1'b0, (mp[0] ? mc : {W{1'b0}})};
  assign acc_nxt        = {sum, acc[W-1:1]};
  assign prod_nxt       = neg ? (~acc_nxt + {{(2*W-1){1'b0}}, 1'b1}) : acc_nxt;
  assign last_iter      = (cnt == CW'(W - 1));
  assign unused_acc_lsb = acc[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      p     <= '0;
      acc   <= '0;
      cnt   <= '0;
      mc    <= '0;
      mp    <= '0;
      neg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mc    <= a_mag;
            mp    <= b_mag;
            neg   <= sgn & (a[W-1] ^ b[W-1]);
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          mp  <= mp >> 1;
          cnt <= cnt + 1'b1;
          if (last_iter) begin
            p     <= prod_nxt;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
